// File: rtl/rect_animator.sv
// Moves the TFT rectangle's top-left corner once every frame_div+1 frames,
// bouncing off the visible edges; a pushbutton toggles between RUN and PAUSED.
module rect_animator #(
  parameter int unsigned X_RES      = 480,
  parameter int unsigned Y_RES      = 272,
  parameter int unsigned RECT_W     = 100,
  parameter int unsigned RECT_H     = 100,
  parameter int unsigned X_NUM_BITS = 10,
  parameter int unsigned Y_NUM_BITS = 9,
  parameter int unsigned X_START    = 0,
  parameter int unsigned Y_START    = 0
) (
  input  logic                  tft_clk,
  input  logic                  rst,
  input  logic                  new_frame,
  input  logic [2:0]            speed,
  input  logic [3:0]            frame_div,
  input  logic                  pause_btn,
  output logic [X_NUM_BITS-1:0] xcorner,
  output logic [Y_NUM_BITS-1:0] ycorner,
  output logic                  x_dir,
  output logic                  y_dir,
  output logic                  paused,
  output logic [7:0]            bounce_count
);

  localparam int unsigned XMAX_I = X_RES - RECT_W;
  localparam int unsigned YMAX_I = Y_RES - RECT_H;
  localparam logic [X_NUM_BITS:0]   XMAX  = XMAX_I[X_NUM_BITS:0];
  localparam logic [Y_NUM_BITS:0]   YMAX  = YMAX_I[Y_NUM_BITS:0];
  localparam logic [X_NUM_BITS-1:0] X_RST = X_START[X_NUM_BITS-1:0];
  localparam logic [Y_NUM_BITS-1:0] Y_RST = Y_START[Y_NUM_BITS-1:0];

  typedef enum logic {RUN, PAUSED} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_new_frame_d;
  logic                  r_pause_btn_d;
  logic [3:0]            r_frame_cnt;
  logic [3:0]            w_frame_cnt_next;
  logic                  w_update;
  logic                  w_tick;
  logic                  w_press;
  logic [X_NUM_BITS-1:0] r_x;
  logic [Y_NUM_BITS-1:0] r_y;
  logic                  r_x_dir;
  logic                  r_y_dir;
  logic [7:0]            r_bounce;

  logic [X_NUM_BITS:0]   w_x_ext, w_x_spd, w_x_sum, w_x_diff;
  logic [Y_NUM_BITS:0]   w_y_ext, w_y_spd, w_y_sum, w_y_diff;
  logic [X_NUM_BITS-1:0] w_x_next;
  logic [Y_NUM_BITS-1:0] w_y_next;
  logic                  w_x_dir_next, w_y_dir_next;
  logic                  w_x_hit, w_y_hit;

  assign w_tick  = new_frame & ~r_new_frame_d;
  assign w_press = pause_btn & ~r_pause_btn_d;

  // One extra bit on every sum so an overshoot past the edge cannot wrap.
  assign w_x_ext  = {1'b0, r_x};
  assign w_y_ext  = {1'b0, r_y};
  assign w_x_spd  = {{(X_NUM_BITS-2){1'b0}}, speed};
  assign w_y_spd  = {{(Y_NUM_BITS-2){1'b0}}, speed};
  assign w_x_sum  = w_x_ext + w_x_spd;
  assign w_y_sum  = w_y_ext + w_y_spd;
  assign w_x_diff = w_x_ext - w_x_spd;
  assign w_y_diff = w_y_ext - w_y_spd;

  always_comb begin
    w_x_next     = r_x;
    w_x_dir_next = r_x_dir;
    w_x_hit      = 1'b0;
    if (r_x_dir) begin
      if (w_x_sum >= XMAX) begin
        w_x_next     = XMAX[X_NUM_BITS-1:0];
        w_x_dir_next = 1'b0;
        w_x_hit      = 1'b1;
      end else begin
        w_x_next = w_x_sum[X_NUM_BITS-1:0];
      end
    end else begin
      if (w_x_ext <= w_x_spd) begin
        w_x_next     = '0;
        w_x_dir_next = 1'b1;
        w_x_hit      = 1'b1;
      end else begin
        w_x_next = w_x_diff[X_NUM_BITS-1:0];
      end
    end
  end

  always_comb begin
    w_y_next     = r_y;
    w_y_dir_next = r_y_dir;
    w_y_hit      = 1'b0;
    if (r_y_dir) begin
      if (w_y_sum >= YMAX) begin
        w_y_next     = YMAX[Y_NUM_BITS-1:0];
        w_y_dir_next = 1'b0;
        w_y_hit      = 1'b1;
      end else begin
        w_y_next = w_y_sum[Y_NUM_BITS-1:0];
      end
    end else begin
      if (w_y_ext <= w_y_spd) begin
        w_y_next     = '0;
        w_y_dir_next = 1'b1;
        w_y_hit      = 1'b1;
      end else begin
        w_y_next = w_y_diff[Y_NUM_BITS-1:0];
      end
    end
  end

  // A press always wins over a coincident tick, in either state.
  always_comb begin
    w_state_next     = r_state;
    w_frame_cnt_next = r_frame_cnt;
    w_update         = 1'b0;
    case (r_state)
      RUN: begin
        if (w_press) begin
          w_state_next = PAUSED;
        end else if (w_tick) begin
          if (r_frame_cnt >= frame_div) begin
            w_update         = 1'b1;
            w_frame_cnt_next = '0;
          end else begin
            w_frame_cnt_next = r_frame_cnt + 4'd1;
          end
        end
      end
      PAUSED: begin
        if (w_press) w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge tft_clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_new_frame_d <= 1'b1;
      r_pause_btn_d <= 1'b1;
      r_frame_cnt   <= '0;
      r_x           <= X_RST;
      r_y           <= Y_RST;
      r_x_dir       <= 1'b1;
      r_y_dir       <= 1'b1;
      r_bounce      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_new_frame_d <= new_frame;
      r_pause_btn_d <= pause_btn;
      r_frame_cnt   <= w_frame_cnt_next;
      if (w_update && (speed != '0)) begin
        r_x     <= w_x_next;
        r_y     <= w_y_next;
        r_x_dir <= w_x_dir_next;
        r_y_dir <= w_y_dir_next;
        if (w_x_hit || w_y_hit) r_bounce <= r_bounce + 8'd1;
      end
    end
  end

  assign xcorner      = r_x;
  assign ycorner      = r_y;
  assign x_dir        = r_x_dir;
  assign y_dir        = r_y_dir;
  assign paused       = (r_state == PAUSED);
  assign bounce_count = r_bounce;

endmodule

// File: tb/tb_rect_animator.sv
// Directed bench for rect_animator: three instances with different start corners,
// status compared as {paused, bounce_count, y_dir, x_dir, ycorner, xcorner}.
module tb_rect_animator;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] fd;
  logic       pb;
  logic       nf  [3];
  logic [2:0] spd [3];

  logic [9:0] xc [3];
  logic [8:0] yc [3];
  logic       xd [3];
  logic       yd [3];
  logic       ps [3];
  logic [7:0] bc [3];
  logic [29:0] st [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rect_animator u_a (
    .tft_clk(clk), .rst(rst), .new_frame(nf[0]), .speed(spd[0]), .frame_div(fd),
    .pause_btn(pb), .xcorner(xc[0]), .ycorner(yc[0]), .x_dir(xd[0]), .y_dir(yd[0]),
    .paused(ps[0]), .bounce_count(bc[0])
  );

  rect_animator #(.X_START(378), .Y_START(170)) u_b (
    .tft_clk(clk), .rst(rst), .new_frame(nf[1]), .speed(spd[1]), .frame_div(fd),
    .pause_btn(1'b0), .xcorner(xc[1]), .ycorner(yc[1]), .x_dir(xd[1]), .y_dir(yd[1]),
    .paused(ps[1]), .bounce_count(bc[1])
  );

  rect_animator #(.X_START(100), .Y_START(170)) u_c (
    .tft_clk(clk), .rst(rst), .new_frame(nf[2]), .speed(spd[2]), .frame_div(fd),
    .pause_btn(1'b0), .xcorner(xc[2]), .ycorner(yc[2]), .x_dir(xd[2]), .y_dir(yd[2]),
    .paused(ps[2]), .bounce_count(bc[2])
  );

  always_comb begin
    for (int i = 0; i < 3; i++) st[i] = {ps[i], bc[i], yd[i], xd[i], yc[i], xc[i]};
  end

  task automatic pulse(input int k, input int len);
    nf[k] = 1'b1;
    repeat (len) @(posedge clk);
    #1 nf[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; fd = 4'd0; pb = 1'b0;
    for (int i = 0; i < 3; i++) begin nf[i] = 1'b1; spd[i] = 3'd3; end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (st[0] !== {1'b0, 8'd0, 1'b1, 1'b1, 9'd0, 10'd0}) begin
      fails++; $display("FAIL reset_a: got %h want %h", st[0], {1'b0, 8'd0, 1'b1, 1'b1, 9'd0, 10'd0});
    end
    tests++;
    if (st[1] !== {1'b0, 8'd0, 1'b1, 1'b1, 9'd170, 10'd378}) begin
      fails++; $display("FAIL reset_b: got %h want %h", st[1], {1'b0, 8'd0, 1'b1, 1'b1, 9'd170, 10'd378});
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (st[0] !== {1'b0, 8'd0, 1'b1, 1'b1, 9'd0, 10'd0}) begin
      fails++; $display("FAIL release_high_nf: got %h want %h", st[0], {1'b0, 8'd0, 1'b1, 1'b1, 9'd0, 10'd0});
    end
    for (int i = 0; i < 3; i++) begin nf[i] = 1'b0; spd[i] = 3'd0; end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    spd[0] = 3'd3; fd = 4'd0;
    nf[0] = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (st[0] !== {1'b0, 8'd0, 1'b1, 1'b1, 9'd3, 10'd3}) begin
      fails++; $display("FAIL basic_latency: got %h want %h", st[0], {1'b0, 8'd0, 1'b1, 1'b1, 9'd3, 10'd3});
    end
    repeat (524) @(posedge clk);
    #1;
    tests++;
    if (st[0] !== {1'b0, 8'd0, 1'b1, 1'b1, 9'd3, 10'd3}) begin
      fails++; $display("FAIL basic_level_once: got %h want %h", st[0], {1'b0, 8'd0, 1'b1, 1'b1, 9'd3, 10'd3});
    end
    nf[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    repeat (3) pulse(0, 2);
    tests++;
    if (st[0] !== {1'b0, 8'd0, 1'b1, 1'b1, 9'd12, 10'd12}) begin
      fails++; $display("FAIL basic_four: got %h want %h", st[0], {1'b0, 8'd0, 1'b1, 1'b1, 9'd12, 10'd12});
    end
  endtask

  task automatic test_divider;
    fd = 4'd2; spd[0] = 3'd1;
    repeat (6) pulse(0, 2);
    tests++;
    if (st[0] !== {1'b0, 8'd0, 1'b1, 1'b1, 9'd14, 10'd14}) begin
      fails++; $display("FAIL div_six: got %h want %h", st[0], {1'b0, 8'd0, 1'b1, 1'b1, 9'd14, 10'd14});
    end
    repeat (2) pulse(0, 2);
    tests++;
    if (st[0] !== {1'b0, 8'd0, 1'b1, 1'b1, 9'd14, 10'd14}) begin
      fails++; $display("FAIL div_count2: got %h want %h", st[0], {1'b0, 8'd0, 1'b1, 1'b1, 9'd14, 10'd14});
    end
    fd = 4'd0;
    pulse(0, 2);
    tests++;
    if (st[0] !== {1'b0, 8'd0, 1'b1, 1'b1, 9'd15, 10'd15}) begin
      fails++; $display("FAIL div_lowered: got %h want %h", st[0], {1'b0, 8'd0, 1'b1, 1'b1, 9'd15, 10'd15});
    end
  endtask

  task automatic test_pause;
    spd[0] = 3'd3; fd = 4'd0;
    nf[0] = 1'b1; pb = 1'b1;
    @(posedge clk);
    #1 nf[0] = 1'b0; pb = 1'b0;
    tests++;
    if (st[0] !== {1'b1, 8'd0, 1'b1, 1'b1, 9'd15, 10'd15}) begin
      fails++; $display("FAIL pause_coincident: got %h want %h", st[0], {1'b1, 8'd0, 1'b1, 1'b1, 9'd15, 10'd15});
    end
    repeat (2) @(posedge clk);
    #1;
    repeat (3) pulse(0, 2);
    tests++;
    if (st[0] !== {1'b1, 8'd0, 1'b1, 1'b1, 9'd15, 10'd15}) begin
      fails++; $display("FAIL pause_hold: got %h want %h", st[0], {1'b1, 8'd0, 1'b1, 1'b1, 9'd15, 10'd15});
    end
    pb = 1'b1;
    @(posedge clk);
    #1 pb = 1'b0;
    @(posedge clk);
    #1;
    pulse(0, 2);
    tests++;
    if (st[0] !== {1'b0, 8'd0, 1'b1, 1'b1, 9'd18, 10'd18}) begin
      fails++; $display("FAIL pause_resume: got %h want %h", st[0], {1'b0, 8'd0, 1'b1, 1'b1, 9'd18, 10'd18});
    end
    pb = 1'b1;
    @(posedge clk);
    #1 pb = 1'b0;
    @(posedge clk);
    #1 nf[0] = 1'b1; pb = 1'b1;
    @(posedge clk);
    #1 nf[0] = 1'b0; pb = 1'b0;
    tests++;
    if (st[0] !== {1'b0, 8'd0, 1'b1, 1'b1, 9'd18, 10'd18}) begin
      fails++; $display("FAIL unpause_tick_ignored: got %h want %h", st[0], {1'b0, 8'd0, 1'b1, 1'b1, 9'd18, 10'd18});
    end
    repeat (2) @(posedge clk);
    #1;
    pulse(0, 2);
    tests++;
    if (st[0] !== {1'b0, 8'd0, 1'b1, 1'b1, 9'd21, 10'd21}) begin
      fails++; $display("FAIL after_unpause: got %h want %h", st[0], {1'b0, 8'd0, 1'b1, 1'b1, 9'd21, 10'd21});
    end
    spd[0] = 3'd0;
    pulse(0, 2);
    tests++;
    if (st[0] !== {1'b0, 8'd0, 1'b1, 1'b1, 9'd21, 10'd21}) begin
      fails++; $display("FAIL speed_zero: got %h want %h", st[0], {1'b0, 8'd0, 1'b1, 1'b1, 9'd21, 10'd21});
    end
  endtask

  task automatic test_corner;
    fd = 4'd0; spd[1] = 3'd5;
    pulse(1, 2);
    tests++;
    if (st[1] !== {1'b0, 8'd1, 1'b0, 1'b0, 9'd172, 10'd380}) begin
      fails++; $display("FAIL corner_hit: got %h want %h", st[1], {1'b0, 8'd1, 1'b0, 1'b0, 9'd172, 10'd380});
    end
    pulse(1, 2);
    tests++;
    if (st[1] !== {1'b0, 8'd1, 1'b0, 1'b0, 9'd167, 10'd375}) begin
      fails++; $display("FAIL corner_return: got %h want %h", st[1], {1'b0, 8'd1, 1'b0, 1'b0, 9'd167, 10'd375});
    end
  endtask

  task automatic test_y_bounce;
    fd = 4'd0; spd[2] = 3'd2;
    pulse(2, 2);
    tests++;
    if (st[2] !== {1'b0, 8'd1, 1'b0, 1'b1, 9'd172, 10'd102}) begin
      fails++; $display("FAIL ybot_hit: got %h want %h", st[2], {1'b0, 8'd1, 1'b0, 1'b1, 9'd172, 10'd102});
    end
    spd[2] = 3'd5;
    repeat (34) pulse(2, 2);
    tests++;
    if (st[2] !== {1'b0, 8'd1, 1'b0, 1'b1, 9'd2, 10'd272}) begin
      fails++; $display("FAIL yup_travel: got %h want %h", st[2], {1'b0, 8'd1, 1'b0, 1'b1, 9'd2, 10'd272});
    end
    spd[2] = 3'd4;
    pulse(2, 2);
    tests++;
    if (st[2] !== {1'b0, 8'd2, 1'b1, 1'b1, 9'd0, 10'd276}) begin
      fails++; $display("FAIL ytop_hit: got %h want %h", st[2], {1'b0, 8'd2, 1'b1, 1'b1, 9'd0, 10'd276});
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_divider;
    test_pause;
    test_corner;
    test_y_bounce;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rect_animator.md
Name: rect_animator

Overview:
- Upstream feeder for the TFT raster driver.
- Once every N frames it moves the displayed rectangle's top-left corner (xcorner, ycorner) and bounces it off the visible screen edges.
- Frame timing comes from the driver's new_frame level. Speed and frame-rate divisor come from board switches, and a pushbutton toggles pause.
- Outputs drive the driver's xcorner/ycorner inputs directly.

Parameters:
- X_RES, 480, visible pixels per line
- Y_RES, 272, visible lines per frame
- RECT_W, 100, rectangle width drawn by the driver (corner + RECT_W)
- RECT_H, 100, rectangle height drawn by the driver
- X_NUM_BITS, 10, width of xcorner
- Y_NUM_BITS, 9, width of ycorner
- X_START, 0, xcorner reset value
- Y_START, 0, ycorner reset value

Ports:
- tft_clk  in  1  pixel clock, shared with the driver
- rst  in  1  reset
- new_frame  in  1  driver level; high for the whole last visible line
- speed  in  3  pixels moved per update on each axis; 0 = frozen
- frame_div  in  4  update every frame_div+1 frames
- pause_btn  in  1  debounced pushbutton level
- xcorner  out  X_NUM_BITS  rectangle left edge, registered
- ycorner  out  Y_NUM_BITS  rectangle top edge, registered
- x_dir  out  1  1 = moving right, 0 = left
- y_dir  out  1  1 = moving down, 0 = up
- paused  out  1  1 while in PAUSED state
- bounce_count  out  8  edge-hit events, wraps 255 -> 0

Behaviour:
- Clock and reset: one clock, tft_clk. Reset rst is synchronous and active-high, and is sampled on the tft_clk rising edge only.
- Reset values:
  - xcorner = X_START, ycorner = Y_START
  - x_dir = 1, y_dir = 1
  - paused = 0 (state RUN)
  - bounce_count = 0, frame_cnt = 0
  - new_frame_d = 1 and pause_btn_d = 1, so a level already high at reset release produces no edge
- Reset mid-operation overrides everything on that edge.
- Edge detect:
  - tick = new_frame & ~new_frame_d
  - press = pause_btn & ~pause_btn_d
  - Both delay registers update every cycle.
- State machine RUN/PAUSED:
  - A press toggles the state.
  - If press and tick occur in the same cycle while in RUN: go to PAUSED and suppress the update.
  - In PAUSED: ticks are ignored and frame_cnt, positions, directions and bounce_count all hold.
  - A press while in PAUSED returns to RUN; a tick in that same cycle is ignored.
- Frame divider (RUN only), on each tick:
  - If frame_cnt >= frame_div: perform an update and set frame_cnt <= 0. The >= comparison covers frame_div being lowered mid-count.
  - Otherwise frame_cnt <= frame_cnt + 1.
- Update: both axes are evaluated in the same cycle. New values are visible on the cycle after the tick edge (1-cycle latency). With speed = 0, nothing changes and no bounce is counted.
- X axis, with XMAX = X_RES - RECT_W (380):
  - Moving right, xcorner + speed >= XMAX: xcorner <= XMAX, x_dir <= 0, bounce.
  - Moving right, otherwise: xcorner <= xcorner + speed.
  - Moving left, xcorner <= speed: xcorner <= 0, x_dir <= 1, bounce.
  - Moving left, otherwise: xcorner <= xcorner - speed.
- Y axis: same rules with YMAX = Y_RES - RECT_H (172).
- Arithmetic: compute sums one bit wider than the corner so they cannot wrap. Corners never leave [0, XMAX] and [0, YMAX].
- bounce_count increments by exactly 1 per update in which either axis bounced; a corner hit counts once.
- Inputs speed and frame_div are sampled at the update edge; no latching is required.

Test Plan:
- Reset: hold rst high 3 cycles with new_frame = 1 -> xcorner = 0, ycorner = 0, x_dir = y_dir = 1, bounce_count = 0. Release with new_frame still high -> no update.
- Basic motion: speed = 3, frame_div = 0, 4 new_frame pulses -> xcorner = 12, ycorner = 12. Each change appears exactly 1 cycle after the new_frame rising edge, and a level held 525 cycles counts once.
- Divider: frame_div = 2, speed = 1, 6 pulses -> xcorner = 2. Then set frame_div = 0 while frame_cnt = 2 -> the next pulse updates.
- Bounce: X_START = 378, speed = 5 -> xcorner = 380, x_dir = 0, bounce_count = 1; next update gives 375. Y at 2 moving up with speed 4 -> ycorner = 0, y_dir = 1.
- Corner: xcorner = 378, ycorner = 170, speed = 5, both axes moving toward the edge -> xcorner = 380, ycorner = 172, bounce_count += 1, both directions flip.
- Pause: press coincident with a due tick -> no movement, paused = 1. 3 further pulses -> no change. Second press, then 1 pulse -> motion resumes. speed = 0 with x = 0 moving left -> no bounce, count unchanged.
